// File: rtl/ram_dp_be_if.sv
// Port bundle for ram_dp_be: write port with byte enables, read port, and status.
// The master drives requests; the slave (the RAM) returns read data and busy.
interface ram_dp_be_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned BYTE_W     = 8
);
  localparam int unsigned NB = DATA_WIDTH / BYTE_W;

  logic                  we;
  logic [NB-1:0]         be;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  re;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  busy;

  modport master (
    output we, be, wr_addr, data_in, re, rd_addr,
    input  data_out, valid_out, busy
  );

  modport slave (
    input  we, be, wr_addr, data_in, re, rd_addr,
    output data_out, valid_out, busy
  );
endinterface

// File: rtl/ram_dp_be.sv
// Simple-dual-port RAM with per-byte write enables, selectable read-during-write,
// optional output register and a post-reset clear sequencer that fills every word.
module ram_dp_be #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 8,
  parameter int unsigned           BYTE_W     = 8,
  parameter int unsigned           RDW_MODE   = 0,
  parameter int unsigned           OUT_REG    = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic        clk,
  input  logic        rst,
  ram_dp_be_if.slave  bus
);

  localparam int unsigned NB    = DATA_WIDTH / BYTE_W;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e                state_q;
  state_e                state_d;
  logic [ADDR_WIDTH-1:0] clr_ptr_q;
  logic [ADDR_WIDTH-1:0] clr_ptr_d;
  logic                  clr_active_c;
  logic                  clr_wr_c;
  logic                  wr_acc_c;
  logic                  rd_acc_c;
  logic [DATA_WIDTH-1:0] rd_word_c;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;

  // State register and clear pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // Next state: sweep every address once, leave CLEAR on the last word
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      ST_CLEAR: begin
        clr_ptr_d = clr_ptr_q + ADDR_WIDTH'(1);
        if (clr_ptr_q == {ADDR_WIDTH{1'b1}}) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // State decode: busy flag and clear-write strobe
  always_comb begin
    clr_active_c = 1'b0;
    case (state_q)
      ST_CLEAR: clr_active_c = 1'b1;
      default:  clr_active_c = 1'b0;
    endcase
  end

  // The clear write is held off while rst is asserted at an edge
  assign clr_wr_c = clr_active_c && !rst;
  assign wr_acc_c = bus.we && !clr_active_c;
  assign rd_acc_c = bus.re && !clr_active_c;
  assign bus.busy = clr_active_c;

  // Storage array; lanes without an enable keep their previous contents
  always_ff @(posedge clk) begin
    if (clr_wr_c) begin
      mem[clr_ptr_q] <= INIT_VALUE;
    end else if (wr_acc_c) begin
      for (int unsigned k = 0; k < NB; k++) begin
        if (bus.be[k]) begin
          mem[bus.wr_addr][k*BYTE_W +: BYTE_W] <= bus.data_in[k*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // Read word, with same-address write lanes forwarded in new-data mode
  always_comb begin
    rd_word_c = mem[bus.rd_addr];
    if ((RDW_MODE != 0) && wr_acc_c && (bus.wr_addr == bus.rd_addr)) begin
      for (int unsigned k = 0; k < NB; k++) begin
        if (bus.be[k]) begin
          rd_word_c[k*BYTE_W +: BYTE_W] = bus.data_in[k*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // First read stage; data only moves when a read is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc_c;
      if (rd_acc_c) begin
        rd_data_q <= rd_word_c;
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_valid_q;

    // Extra output stage, holds data between completed reads
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        out_data_q  <= '0;
        out_valid_q <= 1'b0;
      end else begin
        out_valid_q <= rd_valid_q;
        if (rd_valid_q) begin
          out_data_q <= rd_data_q;
        end
      end
    end

    assign bus.data_out  = out_data_q;
    assign bus.valid_out = out_valid_q;
  end else begin : g_no_out_reg
    assign bus.data_out  = rd_data_q;
    assign bus.valid_out = rd_valid_q;
  end

endmodule
